// File: rtl/frame_fetch.sv
// frame_fetch: streams one frame of pixels from memory into a FIFO through a credit-limited skid buffer.
// Optional macro FRAME_FETCH_PINGPONG_EN adds i_buf_sel to pick buffer 0 or buffer 1.
module frame_fetch #(
  parameter int ADDR_WIDTH   = 19,
  parameter int FRAME_PIXELS = 307200,
  parameter int BASE_ADDR    = 0,
  parameter int CREDITS      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_req,
`ifdef FRAME_FETCH_PINGPONG_EN
  input  logic                  i_buf_sel,
`endif
  output logic                  o_mem_rd,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [11:0]           i_mem_rdata,
  input  logic                  i_mem_rvalid,
  output logic                  o_wr,
  output logic [11:0]           o_wdata,
  input  logic                  i_full,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_err
);

  localparam int PXW = $clog2(FRAME_PIXELS + 1);
  localparam int CW  = $clog2(CREDITS + 1);
  localparam int PW  = $clog2(CREDITS);

  localparam logic [ADDR_WIDTH-1:0] BASE0 =
    ADDR_WIDTH'(BASE_ADDR);
  localparam logic [PXW-1:0] LAST_PIX =
    PXW'(FRAME_PIXELS - 1);
  localparam logic [CW:0] CRED = (CW+1)'(CREDITS);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t state;
  state_t state_n;

  logic [PXW-1:0]        pix;
  logic [CW-1:0]         outst;
  logic [CW-1:0]         occ;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [11:0]           mem [CREDITS];
  logic [ADDR_WIDTH-1:0] base;

  logic start;
  logic issue;
  logic room;
  logic push;
  logic pop;
  logic err_set;

`ifdef FRAME_FETCH_PINGPONG_EN
  localparam logic [ADDR_WIDTH-1:0] BASE1 =
    ADDR_WIDTH'(BASE_ADDR + FRAME_PIXELS);
  assign base = i_buf_sel ? BASE1 : BASE0;
`else
  assign base = BASE0;
`endif

  // Every outstanding read owns a skid slot, so the skid can never overflow.
  assign room = ({1'b0, outst} + {1'b0, occ}) < CRED;

  assign push = i_mem_rvalid && (outst != '0);
  assign pop  = (occ != '0) && !i_full;

  assign o_wr     = pop;
  assign o_wdata  = (occ != '0) ? mem[rd_ptr] : '0;
  assign o_mem_rd = issue;

  assign err_set = (i_req && (state != IDLE))
                || (i_mem_rvalid && (outst == '0));

  always_comb begin
    state_n      = state;
    start        = 1'b0;
    issue        = 1'b0;
    o_busy       = 1'b1;
    o_frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_req) begin
          start   = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH: begin
        issue = room;
        if (room && (pix == LAST_PIX)) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if ((outst == '0) && (occ == '0)) begin
          o_frame_done = 1'b1;
          state_n      = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      o_mem_addr <= BASE0;
      pix        <= '0;
      outst      <= '0;
      occ        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      o_err      <= 1'b0;
    end else begin
      state <= state_n;

      if (start) begin
        o_mem_addr <= base;
        pix        <= '0;
      end else if (issue) begin
        o_mem_addr <= o_mem_addr + 1'b1;
        pix        <= pix + 1'b1;
      end

      unique case ({issue, push})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase

      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (err_set) begin
        o_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_mem_rdata;
    end
  end

  skid_no_overflow: assert property (
    @(posedge i_clk) disable iff (!i_rstn)
    (push && !pop) |-> (occ < CW'(CREDITS))
  );

  credit_bound: assert property (
    @(posedge i_clk) disable iff (!i_rstn)
    ({1'b0, outst} + {1'b0, occ}) <= CRED
  );

endmodule

// File: tb/tb_frame_fetch.sv
// tb_frame_fetch: directed frames against a count-level model of the fetcher,
// with a latency-configurable memory and hand-computed frame timing checks.
module tb_frame_fetch;

  localparam int FP   = 16;
  localparam int CRED = 4;
  localparam int AW   = 19;
`ifdef FRAME_FETCH_PINGPONG_EN
  localparam int T1_FIRST = 16;
`else
  localparam int T1_FIRST = 0;
`endif

  logic          clk = 1'b0;
  logic          i_rstn;
  logic          i_req;
  logic          o_mem_rd;
  logic [AW-1:0] o_mem_addr;
  logic [11:0]   i_mem_rdata;
  logic          i_mem_rvalid;
  logic          o_wr;
  logic [11:0]   o_wdata;
  logic          i_full;
  logic          o_busy;
  logic          o_frame_done;
  logic          o_err;
`ifdef FRAME_FETCH_PINGPONG_EN
  logic          i_buf_sel;
  logic          sel_d;
`endif

  frame_fetch #(
    .ADDR_WIDTH  (AW),
    .FRAME_PIXELS(FP),
    .BASE_ADDR   (0),
    .CREDITS     (CRED)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (i_rstn),
    .i_req       (i_req),
`ifdef FRAME_FETCH_PINGPONG_EN
    .i_buf_sel   (i_buf_sel),
`endif
    .o_mem_rd    (o_mem_rd),
    .o_mem_addr  (o_mem_addr),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_rvalid(i_mem_rvalid),
    .o_wr        (o_wr),
    .o_wdata     (o_wdata),
    .i_full      (i_full),
    .o_busy      (o_busy),
    .o_frame_done(o_frame_done),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int due;
  } rd_t;

  rd_t pend[$];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int lat    = 1;

  logic req_d;
  logic full_d;
  logic rstn_d;

  // model state, in frame-level quantities
  logic m_busy;
  int   m_iss;
  int   m_out;
  int   m_occ;
  int   m_wr;
  int   m_base;
  logic m_err;

  int   fr_wr, fr_iss, fr_first, fr_last;
  int   last_wr_cyc, done_cyc, req_cyc, max_pend;
  logic done_seen;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic step();
    logic ex_rd, ex_wr, ex_done, b;
    rd_t  e;
    @(negedge clk);
    cyc++;
    i_rstn = rstn_d;
    i_req  = req_d;
    i_full = full_d;
`ifdef FRAME_FETCH_PINGPONG_EN
    i_buf_sel = sel_d;
`endif
    if (pend.size() > max_pend) max_pend = pend.size();
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 12'h000;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      e = pend.pop_front();
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 12'(e.addr);
    end
    #1;
    if (!rstn_d) begin
      m_busy = 1'b0;
      m_out  = 0;
      m_occ  = 0;
      m_err  = 1'b0;
      chk("rst_addr", o_mem_addr, 0);
      chk("rst_wdata", o_wdata, 0);
    end
    ex_rd   = m_busy && (m_iss < FP) && (m_out + m_occ < CRED);
    ex_wr   = (m_occ > 0) && !full_d;
    ex_done = m_busy && (m_iss == FP) && (m_out == 0) && (m_occ == 0);
    chk("busy", o_busy, m_busy);
    chk("mem_rd", o_mem_rd, ex_rd);
    chk("wr", o_wr, ex_wr);
    chk("frame_done", o_frame_done, ex_done);
    chk("err", o_err, m_err);
    if (ex_rd && o_mem_rd)
      chk("mem_addr", o_mem_addr, (m_base + m_iss) % (1 << AW));
    if (ex_wr && o_wr)
      chk("wdata", o_wdata, (m_base + m_wr) & 'hfff);

    if (o_mem_rd) begin
      e.addr = int'(o_mem_addr);
      e.due  = cyc + lat;
      pend.push_back(e);
      if (fr_iss == 0) fr_first = int'(o_mem_addr);
      fr_last = int'(o_mem_addr);
      fr_iss++;
    end
    if (o_wr) begin
      fr_wr++;
      last_wr_cyc = cyc;
    end
    if (o_frame_done) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end

    if (rstn_d) begin
      b = m_busy;
      if (i_mem_rvalid) begin
        if (m_out > 0) begin
          m_out--;
          m_occ++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (ex_wr) begin
        m_occ--;
        m_wr++;
      end
      if (ex_rd) begin
        m_out++;
        m_iss++;
      end
      if (ex_done) m_busy = 1'b0;
      if (req_d) begin
        if (b) begin
          m_err = 1'b1;
        end else begin
          m_busy = 1'b1;
          m_iss  = 0;
          m_wr   = 0;
`ifdef FRAME_FETCH_PINGPONG_EN
          m_base = sel_d ? FP : 0;
`else
          m_base = 0;
`endif
        end
      end
    end
  endtask

  task automatic frame_start();
    fr_wr     = 0;
    fr_iss    = 0;
    fr_first  = -1;
    fr_last   = -1;
    done_seen = 1'b0;
    max_pend  = 0;
    req_d     = 1'b1;
    full_d    = 1'b0;
    step();
    req_cyc = cyc;
    req_d   = 1'b0;
  endtask

  // fmode: 0 never full, 1 full held for 100 cycles, 2 full toggling
  task automatic run_frame(input int fmode, input int dup_at);
    int n;
    frame_start();
    n = 0;
    while (!done_seen && n < 2000) begin
      n++;
      req_d = (n == dup_at);
      case (fmode)
        1:       full_d = (n >= 6) && (n < 106);
        2:       full_d = (n % 2) == 1;
        default: full_d = 1'b0;
      endcase
      step();
    end
    req_d  = 1'b0;
    full_d = 1'b0;
    chk("frame_completes", done_seen, 1);
    step();
    chk("busy_after_done", o_busy, 0);
  endtask

  initial begin
    int n;
    i_rstn       = 1'b0;
    i_req        = 1'b0;
    i_full       = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 12'h000;
    req_d        = 1'b0;
    full_d       = 1'b0;
    rstn_d       = 1'b0;
    m_busy       = 1'b0;
    m_err        = 1'b0;
    m_iss        = 0;
    m_out        = 0;
    m_occ        = 0;
    m_wr         = 0;
    m_base       = 0;
    fr_wr        = 0;
    fr_iss       = 0;
    fr_first     = -1;
    fr_last      = -1;
    last_wr_cyc  = 0;
    done_cyc     = 0;
    req_cyc      = 0;
    max_pend     = 0;
    done_seen    = 1'b0;
`ifdef FRAME_FETCH_PINGPONG_EN
    i_buf_sel    = 1'b0;
    sel_d        = 1'b0;
`endif

    repeat (3) step();
    chk("rst_busy", o_busy, 0);
    chk("rst_rd", o_mem_rd, 0);
    rstn_d = 1'b1;
    step();

    // latency 1, never full: 16 pixels, done 19 cycles after the request
    lat = 1;
`ifdef FRAME_FETCH_PINGPONG_EN
    sel_d = 1'b1;
`endif
    run_frame(0, 0);
`ifdef FRAME_FETCH_PINGPONG_EN
    sel_d = 1'b0;
`endif
    chk("t1_writes", fr_wr, 16);
    chk("t1_reads", fr_iss, 16);
    chk("t1_first_addr", fr_first, T1_FIRST);
    chk("t1_last_addr", fr_last, T1_FIRST + 15);
    chk("t1_done_latency", done_cyc - req_cyc, 19);
    chk("t1_done_after_last_wr", done_cyc - last_wr_cyc, 1);

    // latency 3, FIFO full for 100 cycles mid-frame
    lat = 3;
    run_frame(1, 0);
    chk("t2_writes", fr_wr, 16);
    chk("t2_outstanding_le_4", max_pend <= CRED, 1);
    chk("t2_err_clear", o_err, 0);

    // latency 2, FIFO full toggling every cycle
    lat = 2;
    run_frame(2, 0);
    chk("t6_writes", fr_wr, 16);
    chk("t6_err_clear", o_err, 0);

    // second request mid-frame is ignored but flagged
    lat = 1;
    run_frame(0, 5);
    chk("t3_writes", fr_wr, 16);
    chk("t3_first_addr", fr_first, 0);
    chk("t3_err_set", o_err, 1);
    repeat (5) step();
    chk("t3_err_sticky", o_err, 1);

    // reset with pixels 6 and 7 outstanding, then late returns
    lat = 2;
    frame_start();
    n = 0;
    while (fr_iss < 8 && n < 100) begin
      n++;
      step();
    end
    chk("t5_reached_pix7", fr_iss, 8);
    rstn_d = 1'b0;
    step();
    chk("t5_rst_busy", o_busy, 0);
    chk("t5_rst_err", o_err, 0);
    chk("t5_rst_wr", o_wr, 0);
    rstn_d = 1'b1;
    repeat (6) step();
    chk("t5_late_rvalid_err", o_err, 1);
    chk("t5_idle", o_busy, 0);

    lat = 1;
    run_frame(0, 0);
    chk("t5_restart_addr", fr_first, 0);
    chk("t5_restart_writes", fr_wr, 16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/frame_fetch.md
FRAME_FETCH -- requirements
Module: frame_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 19, frame-buffer pixel address width.
REQ-002 Parameter FRAME_PIXELS, default 307200, pixels per frame (640x480).
REQ-003 Parameter BASE_ADDR, default 0, pixel address of first pixel of buffer 0.
REQ-004 Parameter CREDITS, default 4, internal skid-buffer depth and maximum outstanding reads (power of 2, 2..16).
REQ-005 Ports: i_clk  in  1  pixel clock; i_rstn  in  1  reset. One clock; reset is asynchronous and active-low.
REQ-006 Port i_req  in  1  one-cycle frame request from the display stage.
REQ-007 Ports o_mem_rd  out  1  read strobe; o_mem_addr  out  ADDR_WIDTH  read address; i_mem_rdata  in  12  {R,G,B} read data; i_mem_rvalid  in  1  read-data valid, in issue order, latency of 1 or more cycles.
REQ-008 Ports o_wr  out  1  FIFO write; o_wdata  out  12  FIFO write data; i_full  in  1  FIFO full.
REQ-009 Ports o_busy  out  1  frame in progress; o_frame_done  out  1  one-cycle end-of-frame pulse; o_err  out  1  sticky protocol error.

Function
REQ-010 The FSM SHALL have states IDLE, FETCH, DRAIN; reset state IDLE.
REQ-011 IDLE: i_req=1 SHALL load the address counter with the frame base and the pixel counter with 0, and enter FETCH next cycle.
REQ-012 FETCH: o_mem_rd SHALL assert in any cycle where outstanding + skid occupancy < CREDITS; each issue increments o_mem_addr and the pixel counter by 1.
REQ-013 The cycle issuing pixel FRAME_PIXELS-1 SHALL move FETCH to DRAIN; no further reads are issued that frame.
REQ-014 DRAIN: when outstanding = 0 and skid empty, the block SHALL pulse o_frame_done for 1 cycle and return to IDLE.
REQ-015 Each i_mem_rvalid SHALL push i_mem_rdata into the skid buffer and decrement outstanding; a simultaneous issue and return leaves outstanding unchanged.
REQ-016 o_wr SHALL equal (skid not empty AND NOT i_full), combinationally; o_wdata SHALL equal the skid head; a pop occurs on o_wr.
REQ-017 Simultaneous push and pop SHALL keep occupancy unchanged, with data order preserved.
REQ-018 The credit rule SHALL guarantee that the skid buffer never overflows, regardless of how long i_full is held.
REQ-019 i_req in FETCH or DRAIN SHALL be ignored and SHALL set o_err.
REQ-020 i_mem_rvalid with outstanding = 0 SHALL drop the data and set o_err.
REQ-021 o_busy SHALL be 1 in FETCH and DRAIN, and 0 in IDLE.
REQ-022 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; the pixel counter is ceil(log2(FRAME_PIXELS+1)) bits wide.

Reset
REQ-023 On i_rstn=0, at any time: state IDLE; o_mem_rd=0; o_mem_addr=BASE_ADDR; o_wr=0; o_wdata=0; o_busy=0; o_frame_done=0; o_err=0; skid emptied; outstanding=0.
REQ-024 Reset mid-frame SHALL discard the partial frame; memory returns after reset release with outstanding=0 follow REQ-020.

Configuration
REQ-025 Macro FRAME_FETCH_PINGPONG_EN: when defined, the block SHALL add input i_buf_sel (1 bit), sampled on an accepted i_req; the frame base is BASE_ADDR + i_buf_sel*FRAME_PIXELS.
REQ-026 Without FRAME_FETCH_PINGPONG_EN, the i_buf_sel port SHALL NOT exist and the frame base is always BASE_ADDR.

Verification
REQ-027 Memory latency 1, i_full=0, FRAME_PIXELS=16 override, i_req pulse -> 16 writes with data equal to addresses 0..15 in order, then o_frame_done 1 cycle after the last write, then o_busy=0.
REQ-028 Latency 3, i_full held 1 for 100 cycles mid-frame -> at most 4 reads outstanding, no o_wr while full, no lost or duplicated pixel, o_err=0.
REQ-029 Second i_req while o_busy=1 -> frame continues unchanged and o_err=1 until reset.
REQ-030 i_rstn pulsed low at pixel 7 with 2 reads outstanding -> all outputs at reset values immediately; the late rvalids set o_err; a new i_req restarts at BASE_ADDR.
REQ-031 PINGPONG_EN, i_buf_sel=1 at i_req, FRAME_PIXELS=16 -> first o_mem_addr=16, last=31.
REQ-032 i_mem_rvalid with i_full toggling every cycle -> occupancy never exceeds CREDITS, and output order equals issue order.
